// File: rtl/recorder_pkg.sv
// recorder_pkg: shared state encoding and default widths/keys for the recorder and player
package recorder_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;
   localparam int KEY_W = 7;
   localparam int LEN_W = 32;
   localparam logic [KEY_W-1:0] IDLE_KEY = 7'd0;
   localparam logic [KEY_W-1:0] END_KEY = 7'd4;
endpackage

// File: rtl/hold_counter.sv
// hold_counter: loadable down-counter tracking the cycles left on the current note
// ports: clk, rst_n (async, active-low), load/d (reload), en (decrement), q (count), is_one (q==1)
module hold_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         is_one
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (load) q <= d;
      else if (en) q <= q - W'(1);
   assign is_one = q == W'(1);
endmodule

// File: rtl/recording_player.sv
// recording_player: replays (key, length) records as a gapless, cycle-accurate key stream
// ports: clk, rst_n (async, active-low), start/stop/pause controls,
//        rec_valid/rec_ready/rec_key/rec_len record stream, ascii (registered key),
//        playing (FETCH or PLAY), done (pulse after the end marker is taken)
module recording_player #(
   parameter int                KEY_W    = recorder_pkg::KEY_W,
   parameter int                LEN_W    = recorder_pkg::LEN_W,
   parameter logic [KEY_W-1:0]  IDLE_KEY = recorder_pkg::IDLE_KEY,
   parameter logic [KEY_W-1:0]  END_KEY  = recorder_pkg::END_KEY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             rec_valid,
   output logic             rec_ready,
   input  logic [KEY_W-1:0] rec_key,
   input  logic [LEN_W-1:0] rec_len,
   output logic [KEY_W-1:0] ascii,
   output logic             playing,
   output logic             done
);
   import recorder_pkg::*;
   state_t state, state_d;
   logic [LEN_W-1:0] remaining;
   logic is_one, accept, is_end, load, en;
   logic [KEY_W-1:0] ascii_d;
   // ready on the last note cycle lets the next record load with no gap
   assign rec_ready = !stop && (state == FETCH || (state == PLAY && is_one && !pause));
   assign accept = rec_valid && rec_ready;
   assign is_end = rec_key == END_KEY;
   assign load = accept && !is_end && rec_len != '0;
   assign en = state == PLAY && !pause;
   assign playing = state != IDLE;
   hold_counter #(.W(LEN_W)) u_cnt (
      .clk(clk), .rst_n(rst_n), .load(load), .en(en), .d(rec_len), .q(remaining), .is_one(is_one)
   );
   always_comb begin
      state_d = state;
      if (stop) state_d = IDLE;
      else if (state == IDLE) state_d = start ? FETCH : IDLE;
      else if (accept) state_d = is_end ? IDLE : (rec_len == '0 ? FETCH : PLAY);
      else if (state == PLAY && !pause && is_one) state_d = FETCH;
      ascii_d = state_d == PLAY ? (load ? rec_key : ascii) : IDLE_KEY;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         ascii <= IDLE_KEY;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         ascii <= ascii_d;
         done  <= accept && is_end;
      end
endmodule

// File: tb/tb_recording_player.sv
// tb_recording_player: directed checks of playback timing, skip, pause, stop and reset
module tb_recording_player;
   logic clk = 0, rst_n = 0, start = 0, stop = 0, pause = 0, rec_valid = 0, rec_ready;
   logic [6:0] rec_key = 0, ascii;
   logic [31:0] rec_len = 0;
   logic playing, done;
   int n_chk = 0, n_pass = 0, qi = 0;
   bit feed_on = 1;
   logic [6:0] qk[$];
   logic [31:0] ql[$];

   recording_player dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_key(rec_key), .rec_len(rec_len),
      .ascii(ascii), .playing(playing), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic present();
      rec_valid = feed_on && qi < qk.size();
      rec_key = 0;
      rec_len = 0;
      if (rec_valid) begin
         rec_key = qk[qi];
         rec_len = ql[qi];
      end
   endtask

   // advance one clock, consuming the presented record if the handshake fired
   task automatic step();
      logic acc;
      acc = rec_valid && rec_ready;
      @(posedge clk);
      #1;
      if (acc) qi++;
      present();
      #1;
   endtask

   task automatic begin_play();
      qi = 0;
      present();
      start = 1;
      step();
      start = 0;
   endtask

   task automatic go_idle();
      stop = 1;
      step();
      stop = 0;
      pause = 0;
   endtask

   initial begin
      logic [6:0] e1[8];
      logic [6:0] e2[6];
      e1 = '{7'h00, 7'h41, 7'h41, 7'h41, 7'h42, 7'h42, 7'h00, 7'h00};
      e2 = '{7'h00, 7'h41, 7'h41, 7'h00, 7'h44, 7'h00};
      #12;
      check("rst_ascii", ascii, 0);
      check("rst_done", done, 0);
      check("rst_ready", rec_ready, 0);
      check("rst_playing", playing, 0);
      @(posedge clk);
      #1 rst_n = 1;
      step();

      // basic sequence with end marker
      qk = '{7'h41, 7'h42, 7'h04};
      ql = '{32'd3, 32'd2, 32'd0};
      begin_play();
      for (int i = 1; i <= 8; i++) begin
         if (i > 1) step();
         check($sformatf("seq1_ascii_c%0d", i), ascii, e1[i-1]);
         check($sformatf("seq1_done_c%0d", i), done, i == 7);
      end
      check("seq1_playing_end", playing, 0);
      check("seq1_consumed", qi, 3);

      // zero-length record skipped with one idle cycle
      qk = '{7'h41, 7'h43, 7'h44};
      ql = '{32'd2, 32'd0, 32'd1};
      begin_play();
      for (int i = 1; i <= 6; i++) begin
         if (i > 1) step();
         check($sformatf("skip_ascii_c%0d", i), ascii, e2[i-1]);
      end
      check("skip_playing_fetch", playing, 1);
      go_idle();
      check("skip_stop_idle", playing, 0);

      // pause stretches the note and blocks handover
      qk = '{7'h41};
      ql = '{32'd5};
      begin_play();
      for (int i = 2; i <= 10; i++) begin
         step();
         pause = i >= 3 && i <= 5;
         #1;
         check($sformatf("pause_ascii_c%0d", i), ascii, i <= 9 ? 7'h41 : 7'h00);
         if (i >= 3 && i <= 5) check($sformatf("pause_ready_c%0d", i), rec_ready, 0);
      end
      pause = 0;
      go_idle();

      // stop mid-note leaves the next record unconsumed
      qk = '{7'h41, 7'h42};
      ql = '{32'd4, 32'd1};
      begin_play();
      step();
      check("stop_note", ascii, 7'h41);
      step();
      stop = 1;
      #1;
      check("stop_ready", rec_ready, 0);
      step();
      stop = 0;
      check("stop_ascii", ascii, 0);
      check("stop_playing", playing, 0);
      check("stop_not_consumed", qi, 1);

      // underrun in FETCH
      qk = '{7'h45};
      ql = '{32'd1};
      feed_on = 0;
      begin_play();
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) step();
         check($sformatf("under_ascii_c%0d", i), ascii, 0);
         check($sformatf("under_playing_c%0d", i), playing, 1);
      end
      feed_on = 1;
      step();
      step();
      check("under_note", ascii, 7'h45);
      step();
      check("under_after", ascii, 0);
      check("under_refetch", playing, 1);
      go_idle();

      // async reset mid-note, then clean restart
      qk = '{7'h41};
      ql = '{32'd10};
      begin_play();
      step();
      step();
      check("rstmid_note", ascii, 7'h41);
      rst_n = 0;
      #1;
      check("rstmid_ascii", ascii, 0);
      check("rstmid_ready", rec_ready, 0);
      check("rstmid_done", done, 0);
      check("rstmid_playing", playing, 0);
      step();
      rst_n = 1;
      qk = '{7'h41, 7'h04};
      ql = '{32'd1, 32'd0};
      begin_play();
      check("restart_fetch", playing, 1);
      step();
      check("restart_note", ascii, 7'h41);
      step();
      check("restart_done", done, 1);
      check("restart_ascii", ascii, 0);
      check("restart_playing", playing, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
